// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared encodings for the pong datapath: bounce event codes,
//                default screen geometry and the ball state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int SCREEN_X_DEFAULT = 640;
    localparam int SCREEN_Y_DEFAULT = 480;

    // Collision events reported to the ball controller
    typedef enum logic [1:0] {
        BOUNCE_NONE   = 2'd0,
        BOUNCE_PADDLE = 2'd1,
        BOUNCE_WALL   = 2'd2,
        BOUNCE_SCORE  = 2'd3
    } bounce_t;

    // Ball controller states
    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_MOVE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } ball_state_t;

endpackage
`default_nettype wire

// File: rtl/ball_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_fsm_if
//  Description : Frame/collision inputs and ball geometry outputs of the ball
//                controller. master = game logic side, slave = ball_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ball_fsm_if;
    logic       frame_tick;
    logic       pause;
    logic [1:0] bounce;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic [7:0] ball_size_x;
    logic [7:0] ball_size_y;
    logic       serving;

    modport master (
        output frame_tick, pause, bounce,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, serving
    );

    modport slave (
        input  frame_tick, pause, bounce,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, serving
    );
endinterface
`default_nettype wire

// File: rtl/ball_axis.sv
`default_nettype none
// ============================================================================
//  Module      : ball_axis
//  Description : One-axis signed step with saturation to [0, MAX_POS].
//                11-bit signed intermediate so neither edge can wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_axis #(
    parameter int STEP    = 1,
    parameter int MAX_POS = 632
) (
    input  logic [9:0] pos,
    input  logic       dir,
    output logic [9:0] next_pos
);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] MAX_S  = 11'(MAX_POS);

    logic signed [10:0] sum;

    // Step in the requested direction, then clamp into the legal window
    always_comb begin
        sum = dir ? ($signed({1'b0, pos}) + STEP_S) : ($signed({1'b0, pos}) - STEP_S);
        if (sum < 11'sd0) begin
            next_pos = '0;
        end else if (sum > MAX_S) begin
            next_pos = MAX_S[9:0];
        end else begin
            next_pos = sum[9:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/ball_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ball_fsm
//  Description : Pong ball controller. Holds the ball at centre while serving,
//                then steps it once per frame, reacting to paddle/wall/score
//                events with a short post-bounce ignore window.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_fsm
    import pong_pkg::*;
#(
    parameter int SCREEN_X     = SCREEN_X_DEFAULT,
    parameter int SCREEN_Y     = SCREEN_Y_DEFAULT,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED_X      = 2,
    parameter int SPEED_Y      = 1,
    parameter int SERVE_FRAMES = 60,
    parameter int COOLDOWN     = 4
) (
    input  logic       clock,
    input  logic       reset,
    ball_fsm_if.slave  bus
);
    localparam logic [9:0]  X_MAX      = 10'(SCREEN_X - BALL_SIZE);
    localparam logic [9:0]  Y_MAX      = 10'(SCREEN_Y - BALL_SIZE);
    localparam logic [9:0]  X_C        = 10'((SCREEN_X - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_C        = 10'((SCREEN_Y - BALL_SIZE) / 2);
    localparam logic [7:0]  SIZE8      = 8'(BALL_SIZE);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [15:0] COOL_LAST  = 16'(COOLDOWN - 1);

    ball_state_t state;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        dir_x;
    logic        dir_y;
    logic [15:0] serve_cnt;
    logic [15:0] cool_cnt;

    logic        paddle_hit;
    logic        wall_hit;
    logic        dir_x_eff;
    logic        dir_y_eff;
    logic [9:0]  next_x;
    logic [9:0]  next_y;

    // Bounces only act in MOVE; the flipped direction is used by a same-cycle step
    always_comb begin
        paddle_hit = (state == ST_MOVE) && (bus.bounce == BOUNCE_PADDLE);
        wall_hit   = (state == ST_MOVE) && (bus.bounce == BOUNCE_WALL);
        dir_x_eff  = dir_x ^ paddle_hit;
        dir_y_eff  = dir_y ^ wall_hit;
    end

    ball_axis #(.STEP(SPEED_X), .MAX_POS(SCREEN_X - BALL_SIZE)) u_axis_x (
        .pos      (pos_x),
        .dir      (dir_x_eff),
        .next_pos (next_x)
    );

    ball_axis #(.STEP(SPEED_Y), .MAX_POS(SCREEN_Y - BALL_SIZE)) u_axis_y (
        .pos      (pos_y),
        .dir      (dir_y_eff),
        .next_pos (next_y)
    );

    // Ball state machine: serve hold, motion, bounce cooldown and score restart
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_SERVE;
            pos_x     <= X_C;
            pos_y     <= Y_C;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            serve_cnt <= '0;
            cool_cnt  <= '0;
        end else if (!bus.pause) begin
            case (state)
                ST_SERVE: begin
                    if (bus.frame_tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            state     <= ST_MOVE;
                            serve_cnt <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 16'd1;
                        end
                    end
                end
                ST_MOVE, ST_COOLDOWN: begin
                    if (bus.bounce == BOUNCE_SCORE) begin
                        // Restart from centre, serving toward the other side
                        state     <= ST_SERVE;
                        pos_x     <= X_C;
                        pos_y     <= Y_C;
                        dir_x     <= ~dir_x;
                        serve_cnt <= '0;
                        cool_cnt  <= '0;
                    end else begin
                        dir_x <= dir_x_eff;
                        dir_y <= dir_y_eff;
                        if (bus.frame_tick) begin
                            pos_x <= next_x;
                            pos_y <= next_y;
                        end
                        if (state == ST_MOVE) begin
                            if (paddle_hit || wall_hit) begin
                                state    <= ST_COOLDOWN;
                                cool_cnt <= '0;
                            end
                        end else if (bus.frame_tick) begin
                            if (cool_cnt == COOL_LAST) begin
                                state    <= ST_MOVE;
                                cool_cnt <= '0;
                            end else begin
                                cool_cnt <= cool_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= ST_SERVE;
                    pos_x     <= X_C;
                    pos_y     <= Y_C;
                    serve_cnt <= '0;
                    cool_cnt  <= '0;
                end
            endcase
        end
    end

    assign bus.ball_pos_x  = pos_x;
    assign bus.ball_pos_y  = pos_y;
    assign bus.ball_size_x = SIZE8;
    assign bus.ball_size_y = SIZE8;
    assign bus.serving     = (state == ST_SERVE);

    // Saturation limits are carried by the axis instances; keep them visible here too
    logic unused_limits;
    assign unused_limits = ^{X_MAX, Y_MAX};
endmodule
`default_nettype wire

// File: tb/tb_ball_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_fsm
//  Description : Directed self-checking bench for ball_fsm with a behavioural
//                model feeding an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_fsm;
    localparam int XC = 316;
    localparam int YC = 236;
    localparam int XMAX = 632;
    localparam int YMAX = 472;
    localparam int SX = 2;
    localparam int SY = 1;
    localparam int SERVE_N = 60;
    localparam int COOL_N = 4;

    typedef struct {
        int x;
        int y;
        int serving;
    } exp_t;

    logic clock;
    logic reset;
    ball_fsm_if bus ();

    ball_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t sb[$];

    // Behavioural model state: 0 serve, 1 move, 2 cooldown
    int m_state, m_x, m_y, m_sc, m_cc;
    bit m_dx, m_dy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = XC; m_y = YC; m_dx = 1'b1; m_dy = 1'b1; m_sc = 0; m_cc = 0;
    endtask

    task automatic model(input bit tk, input int bn, input bit pz);
        bit dx, dy;
        int nx, ny, old;
        if (pz) return;
        if (m_state == 0) begin
            if (tk) begin
                if (m_sc == SERVE_N - 1) begin m_state = 1; m_sc = 0; end
                else m_sc++;
            end
            return;
        end
        if (bn == 3) begin
            m_state = 0; m_x = XC; m_y = YC; m_dx = !m_dx; m_sc = 0; m_cc = 0;
            return;
        end
        old = m_state;
        dx = m_dx; dy = m_dy;
        if (old == 1 && bn == 1) dx = !dx;
        if (old == 1 && bn == 2) dy = !dy;
        m_dx = dx; m_dy = dy;
        if (tk) begin
            nx = dx ? m_x + SX : m_x - SX;
            ny = dy ? m_y + SY : m_y - SY;
            m_x = (nx < 0) ? 0 : (nx > XMAX) ? XMAX : nx;
            m_y = (ny < 0) ? 0 : (ny > YMAX) ? YMAX : ny;
        end
        if (old == 1 && (bn == 1 || bn == 2)) begin
            m_state = 2; m_cc = 0;
        end else if (old == 2 && tk) begin
            if (m_cc == COOL_N - 1) begin m_state = 1; m_cc = 0; end
            else m_cc++;
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, compare after the edge
    task automatic cyc(input bit tk, input int bn, input bit pz);
        exp_t e;
        bus.frame_tick = tk;
        bus.bounce = 2'(bn);
        bus.pause = pz;
        model(tk, bn, pz);
        e.x = m_x; e.y = m_y; e.serving = (m_state == 0) ? 1 : 0;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("pos_x", 32'(bus.ball_pos_x), 32'(e.x));
        check("pos_y", 32'(bus.ball_pos_y), 32'(e.y));
        check("serving", 32'(bus.serving), 32'(e.serving));
        bus.frame_tick = 1'b0;
        bus.bounce = 2'd0;
        bus.pause = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(bus.ball_pos_x), 32'(x));
        check({tag, "_y"}, 32'(bus.ball_pos_y), 32'(y));
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_tick = 1'b0;
        bus.pause = 1'b0;
        bus.bounce = 2'd0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_pos("reset", XC, YC);
        check("reset_serving", 32'(bus.serving), 32'd1);
        check("size_x", 32'(bus.ball_size_x), 32'd8);
        check("size_y", 32'(bus.ball_size_y), 32'd8);
        reset = 1'b0;

        // Serve hold: 59 ticks still serving, 60th leaves SERVE, 61st moves
        repeat (59) cyc(1, 0, 0);
        check("serve_59", 32'(bus.serving), 32'd1);
        cyc(1, 0, 0);
        check("serve_60", 32'(bus.serving), 32'd0);
        check_pos("serve_60", XC, YC);
        cyc(1, 0, 0);
        check_pos("first_move", 318, 237);

        // Steer to (400,200) moving +x/+y in MOVE
        cyc(0, 2, 0);
        repeat (4) cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (4) cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (35) cyc(1, 0, 0);
        cyc(0, 2, 0);
        repeat (6) cyc(1, 0, 0);
        check_pos("setup", 400, 200);

        // Held paddle bounce: single flip, same-cycle step uses new direction
        cyc(1, 1, 0);
        check_pos("paddle_flip", 398, 201);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        repeat (4) cyc(1, 1, 0);
        check_pos("paddle_held", 390, 205);

        // Left edge saturation, then bottom edge saturation
        repeat (195) cyc(1, 0, 0);
        check_pos("left_edge", 0, 400);
        cyc(1, 0, 0);
        check_pos("left_sat", 0, 401);
        repeat (75) cyc(1, 0, 0);
        check_pos("bottom_sat", 0, YMAX);

        // Wall bounce near top; repeated wall inside cooldown ignored
        cyc(0, 2, 0);
        repeat (467) cyc(1, 0, 0);
        check_pos("near_top", 0, 5);
        cyc(1, 2, 0);
        check_pos("wall_flip", 0, 6);
        cyc(1, 2, 0);
        check_pos("wall_ignored", 0, 7);
        repeat (3) cyc(1, 0, 0);
        check_pos("wall_rise", 0, 10);

        // Pause in COOLDOWN with paddle bounce asserted: nothing moves
        cyc(1, 1, 0);
        check_pos("pre_pause", 2, 11);
        repeat (10) cyc(1, 1, 1);
        check_pos("paused", 2, 11);
        cyc(1, 0, 0);
        check_pos("post_pause", 4, 12);

        // Score during COOLDOWN with simultaneous tick: centre, serve, dir_x flipped
        cyc(1, 3, 0);
        check_pos("score", XC, YC);
        check("score_serving", 32'(bus.serving), 32'd1);
        repeat (SERVE_N) cyc(1, 0, 0);
        cyc(1, 0, 0);
        check_pos("serve_other_side", 314, 237);

        // Asynchronous reset mid-COOLDOWN
        cyc(0, 2, 0);
        cyc(1, 0, 0);
        check_pos("pre_reset", 312, 236);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_pos("async_reset", XC, YC);
        check("async_reset_serving", 32'(bus.serving), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (SERVE_N - 1) cyc(1, 0, 0);
        check("reserve_59", 32'(bus.serving), 32'd1);
        cyc(1, 0, 0);
        check("reserve_60", 32'(bus.serving), 32'd0);
        cyc(1, 0, 0);
        check_pos("reserve_move", 318, 237);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ball_fsm.md
BALL_FSM -- requirements
Module: ball_fsm

Interface
REQ-001 Parameters SHALL be: SCREEN_X, default 640, screen width in pixels; SCREEN_Y, default 480, screen height in pixels; BALL_SIZE, default 8, ball edge in pixels; SPEED_X, default 2, x step per frame; SPEED_Y, default 1, y step per frame; SERVE_FRAMES, default 60, serve hold frames; COOLDOWN, default 4, post-bounce ignore frames.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse per video frame; the only motion enable.
REQ-005 pause  input  1  high freezes position, direction and all counters.
REQ-006 bounce  input  2  event from collision logic: 0 none, 1 paddle, 2 wall, 3 score.
REQ-007 ball_pos_x  output  10  ball left edge, registered.
REQ-008 ball_pos_y  output  10  ball top edge, registered.
REQ-009 ball_size_x, ball_size_y  output  8 each  constant BALL_SIZE.
REQ-010 serving  output  1  high while in SERVE state.

Function
REQ-011 States SHALL be SERVE, MOVE and COOLDOWN, held in a 2-bit state register.
REQ-012 SERVE: position held at centre, X_C=(SCREEN_X-BALL_SIZE)/2=316, Y_C=(SCREEN_Y-BALL_SIZE)/2=236; bounce ignored; serve counter increments on each frame_tick.
REQ-013 SERVE->MOVE when the serve counter reaches SERVE_FRAMES-1 on a frame_tick; no motion occurs on that tick; the counter clears.
REQ-014 MOVE, on frame_tick: x += SPEED_X if dir_x=1, else x -= SPEED_X; y += SPEED_Y if dir_y=1, else y -= SPEED_Y.
REQ-015 Arithmetic SHALL use 11-bit intermediates; x saturates to [0, SCREEN_X-BALL_SIZE] and y to [0, SCREEN_Y-BALL_SIZE]; no wrap-around.
REQ-016 MOVE with bounce=1: invert dir_x, clear the cooldown counter, go to COOLDOWN.
REQ-017 MOVE with bounce=2: invert dir_y, clear the cooldown counter, go to COOLDOWN.
REQ-018 Direction inversion and frame_tick in the same cycle: the step SHALL use the inverted direction.
REQ-019 COOLDOWN: motion identical to MOVE; bounce 1 and 2 ignored; counter increments per frame_tick; return to MOVE on the tick where the counter reaches COOLDOWN-1.
REQ-020 bounce=3 in MOVE or COOLDOWN: next cycle, position = centre, dir_x inverted (serve alternates sides), dir_y kept, counters cleared, state SERVE; this overrides any simultaneous frame_tick.
REQ-021 pause=1 SHALL take priority over frame_tick and bounce, with events during pause discarded; reset SHALL take priority over pause.
REQ-022 Outputs are registers, so a position update is visible one cycle after the triggering edge.
REQ-023 serving SHALL be high exactly while state=SERVE.

Reset
REQ-024 Asserting reset at any time, including mid-move or mid-cooldown, SHALL asynchronously force: state SERVE, ball_pos_x=316, ball_pos_y=236, dir_x=1, dir_y=1, both counters 0, serving=1.
REQ-025 On reset release the block SHALL start a full SERVE_FRAMES hold.

Structure
REQ-026 A shared package pong_pkg SHALL hold the bounce encodings (BOUNCE_NONE/PADDLE/WALL/SCORE), SCREEN_X/SCREEN_Y defaults and the state encoding; the collision block SHALL use the same encodings.
REQ-027 One sub-module ball_axis (single-axis signed step with saturation, instanced for x and y) SHALL be used; the rest is flat.

Verification
REQ-028 Reset, then 60 frame_ticks -> serving=1 and position (316,236) throughout; serving=0 after the 60th tick; first move to (318,237) on the 61st tick.
REQ-029 In MOVE at (400,200) moving +x/+y: bounce=1 held 3 cycles with a tick in cycle 1 -> single dir_x flip, position (398,201); held bounce ignored for 4 ticks.
REQ-030 Bounce=2 at y=5 moving -y -> dir_y flips, y rises by 1 per tick; repeat bounce=2 within cooldown -> no second flip.
REQ-031 x=1 moving -x, tick with no bounce -> x saturates to 0, no underflow to 1023.
REQ-032 Bounce=3 while in COOLDOWN with a simultaneous tick -> next cycle (316,236), serving=1, dir_x inverted relative to before.
REQ-033 pause=1 for 10 ticks with bounce=1 asserted -> position, direction and state unchanged; reset asserted mid-COOLDOWN -> immediate centre, state SERVE.
